// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam int UART_DATA_BITS   = 8;
    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop single-bit synchroniser with a selectable reset value, so idle-high
// lines (RX, CTS) do not look like an edge when reset is released.
module uart_sync #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, controls the receive half of the
// baud generator and samples each bit on the generator's mid-bit tick.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RX_IDLE   | generator disabled, waiting for a falling edge on the line
// RX_START  | waiting for the mid start-bit tick to confirm the start bit
// RX_DATA   | sampling data bits LSB first, one per tick
// RX_PARITY | sampling and checking the parity bit
// RX_STOP   | sampling the stop bit, then reporting the word or the error
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = PARITY_MODE_EVEN
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 rx_serial_i,
    input  logic                 rx_baud_tick_i,
    output logic                 rx_baud_en_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 rx_busy_o
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic                 rx_sync;
    logic                 rx_prev_q;
    logic                 start_edge;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 xor_q;
    logic                 perr_q;
    logic                 baud_en_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clock_i),
        .rst_ni(reset_ni),
        .d_i   (rx_serial_i),
        .q_o   (rx_sync)
    );

    // History flop for falling-edge detection; resets high like the line.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_sync;
        end
    end

    assign start_edge = rx_prev_q & ~rx_sync;

    // Receive FSM with registered outputs and the output handshake.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= RX_IDLE;
            shift_q      <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            xor_q        <= 1'b0;
            perr_q       <= 1'b0;
            baud_en_q    <= 1'b0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;

            if (valid_q && rx_ready_i) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (start_edge) begin
                        state_q   <= RX_START;
                        baud_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                RX_START: begin
                    if (rx_baud_tick_i) begin
                        if (!rx_sync) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                            xor_q     <= 1'b0;
                            perr_q    <= 1'b0;
                        end else begin
                            // Line went back high before mid-bit: glitch, not a start bit.
                            state_q   <= RX_IDLE;
                            baud_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                end

                RX_DATA: begin
                    if (rx_baud_tick_i) begin
                        shift_q   <= {rx_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        xor_q     <= xor_q ^ rx_sync;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PARITY_EN ? RX_PARITY : RX_STOP;
                        end
                    end
                end

                RX_PARITY: begin
                    if (rx_baud_tick_i) begin
                        perr_q  <= (rx_sync != (xor_q ^ PARITY_ODD));
                        state_q <= RX_STOP;
                    end
                end

                RX_STOP: begin
                    if (rx_baud_tick_i) begin
                        if (!rx_sync) begin
                            frame_err_q <= 1'b1;
                        end
                        if (perr_q) begin
                            parity_err_q <= 1'b1;
                        end
                        if (rx_sync && !perr_q) begin
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
                            // A word still pending and not taken this cycle is lost.
                            overrun_q <= valid_q & ~rx_ready_i;
                        end
                        // Always pass through IDLE so the generator re-arms its half-bit phase.
                        state_q   <= RX_IDLE;
                        baud_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= RX_IDLE;
                    baud_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rx_baud_en_o = baud_en_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign rx_busy_o    = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that deserialises the asynchronous serial line into parallel bytes.
- Owns the receive-side enable of the shared baud-rate generator and consumes that generator's receive tick.
- Samples the start bit once at mid-bit, then each following bit at mid-bit.
- Presents each received word through a valid/ready handshake with overrun, framing and parity status.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- PARITY_EN, 0, 1 = one parity bit is expected between the data bits and the stop bit.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_serial  in  1  serial line, idle high; asynchronous to clock.
- rx_baud_tick  in  1  one-cycle tick from the baud generator: first tick after enable = mid start bit, then one tick per bit period.
- rx_baud_en  out  1  drives the generator's receive enable; low clears the generator's count and half-bit phase.
- rx_data  out  DATA_BITS  last good received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  sticky: a frame completed while rx_valid was still high; cleared on handshake.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rx_baud_en=0; rx_data=0; rx_valid=0; frame_err=0; parity_err=0; overrun=0; rx_busy=0; bit counter=0.
- Synchroniser state resets to 1 so that release from reset is not seen as a start edge.
- Input path: rx_serial passes through a 2-flop synchroniser plus one history flop; a start edge is sync=0 with prev=1.
- Start-edge latency: 3 clocks from the pin edge to the START state.
- IDLE: rx_baud_en=0. On a start edge, go to START and set rx_baud_en=1 in the same registered update.
- START: on tick, sync=0 -> DATA with bit_cnt=0. On tick, sync=1 (false start) -> IDLE with rx_baud_en=0, no flags.
- DATA: on each tick, shift sync into the shift register MSB-side, so the first received bit ends in bit 0. Increment bit_cnt and fold the bit into a running XOR. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: on tick, expected bit = XOR of data ^ PARITY_ODD. On mismatch, set an internal perr flag. Go to STOP.
- STOP, tick with sync=1:
  - if perr=0: load rx_data, set rx_valid=1.
  - if rx_valid was already 1 and not handshaken this cycle: overwrite rx_data and set overrun=1.
- STOP, tick with sync=0: pulse frame_err. rx_data and rx_valid are unchanged.
- STOP, perr=1: pulse parity_err. rx_data and rx_valid are unchanged.
- Leaving STOP: go to IDLE with rx_baud_en=0 on the following clock. Every STOP exit passes through IDLE for at least one cycle so the generator restarts its half-bit phase.
- Handshake: rx_valid & rx_ready clears rx_valid and overrun next cycle. A completion in the same cycle as a handshake loads new data with rx_valid=1 and overrun=0.
- Ticks arriving in IDLE are ignored.
- Ticks are processed only in the cycle they are high; no tick is counted twice.
- Line glitch shorter than the synchroniser delay: handled by the START false-start check.
- Reset asserted mid-frame: immediate return to the reset values; the partial word is discarded and the generator is disabled.

Decomposition:
- Package uart_pkg: rx_state_e enum (IDLE, START, DATA, PARITY, STOP), default DATA_BITS constant, parity-mode constants.
- Sub-module: uart_sync, a 2-flop bit synchroniser with a reset-value parameter; it is reusable for CTS and similar inputs.
- Bit counter width: $clog2(DATA_BITS+1).

Test Plan:
- Bench instantiates the baud generator with baud_rate=16'd15, wiring rx_baud_en and rx_baud_tick.
  - Send 8'hA5 (8N1), rx_ready=1 -> rx_valid pulses once, rx_data=8'hA5, no flags.
  - Each data sample lands within ±1 clock of bit centre.
- Send 8'h3C, then 8'hC3, with rx_ready=0 -> after the second stop bit, rx_data=8'hC3, rx_valid=1, overrun=1. Then rx_ready=1 for 1 cycle -> rx_valid=0, overrun=0.
- Drive the stop bit low on 8'h55 -> frame_err one-cycle pulse, rx_valid stays 0, rx_baud_en drops, and the next good frame 8'h0F is received correctly.
- rx_serial low pulse of 4 clocks (shorter than a half bit) -> START rejects it at the mid-bit tick, returns to IDLE, no flags, rx_valid=0.
- PARITY_EN=1, PARITY_ODD=0: send 8'h07 with parity bit 1 -> accepted. Send 8'h07 with parity bit 0 -> parity_err pulse, rx_valid unchanged.
- Assert reset during data bit 3 of 8'hFF -> all outputs at reset values asynchronously. After release, 8'h81 is received correctly.
